// File: rtl/cobalt_pkg.sv
// Shared integer-pipeline types: default field widths, the issue-queue
// entry layout and the CDB tag-match helper used by dispatch and wakeup.
package cobalt_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] rs_data;
        logic              rs_valid;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rt_data;
        logic              rt_valid;
        logic [TAG_W-1:0]  rt_tag;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    // A waiting source captures the CDB when its producer tag is broadcast.
    function automatic logic src_hit(input logic             src_valid,
                                     input logic [TAG_W-1:0] src_tag,
                                     input logic             cdb_valid,
                                     input logic [TAG_W-1:0] cdb_tag);
        return !src_valid && cdb_valid && (src_tag == cdb_tag);
    endfunction

endpackage

// File: rtl/issueque_entry.sv
// One issue-queue slot's wakeup logic: CDB compare/capture for both sources
// and the slot's ready flag. Build option ISSUEQUE_CDB_BYPASS_EN lets the
// ready flag and forwarded operands see the same-cycle CDB match.
module issueque_entry
    import cobalt_pkg::*;
(
    input  logic              valid_i,
    input  logic              rs_valid_i,
    input  logic [TAG_W-1:0]  rs_tag_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic              rt_valid_i,
    input  logic [TAG_W-1:0]  rt_tag_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              rs_valid_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic              rt_valid_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] rs_fwd_o,
    output logic [DATA_W-1:0] rt_fwd_o
);

    logic rs_hit;
    logic rt_hit;

    // Post-wakeup source state that the slot will hold after this edge.
    always_comb begin
        rs_hit     = valid_i && src_hit(rs_valid_i, rs_tag_i, cdb_valid_i, cdb_tag_i);
        rt_hit     = valid_i && src_hit(rt_valid_i, rt_tag_i, cdb_valid_i, cdb_tag_i);
        rs_valid_o = rs_valid_i | rs_hit;
        rt_valid_o = rt_valid_i | rt_hit;
        rs_data_o  = rs_hit ? cdb_data_i : rs_data_i;
        rt_data_o  = rt_hit ? cdb_data_i : rt_data_i;
    end

`ifdef ISSUEQUE_CDB_BYPASS_EN
    // Readiness and operands include the broadcast landing this cycle.
    always_comb begin
        ready_o  = valid_i & rs_valid_o & rt_valid_o;
        rs_fwd_o = rs_data_o;
        rt_fwd_o = rt_data_o;
    end
`else
    // Readiness from stored state only; keeps cdb_* off the ready path.
    always_comb begin
        ready_o  = valid_i & rs_valid_i & rt_valid_i;
        rs_fwd_o = rs_data_i;
        rt_fwd_o = rt_data_i;
    end
`endif

endmodule

// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered, compacting buffer of DEPTH entries.
// Slot 0 is oldest; valid slots are contiguous from 0. Select picks the
// oldest ready slot; a grant removes it and shifts younger slots down.
// Build option ISSUEQUE_CDB_BYPASS_EN (see issueque_entry) adds same-cycle
// CDB wakeup to readiness and operand forwarding.
module issueque_int
    import cobalt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              dispatch_en,
    input  logic [OPC_W-1:0]  dispatch_opcode,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic              dispatch_rsvalid,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rtvalid,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    output logic              issueque_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    output logic              ready_int,
    input  logic              issue_int,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] rsdata,
    output logic [DATA_W-1:0] rtdata,
    output logic [TAG_W-1:0]  rdtag
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    entry_t            slot_q [DEPTH];
    entry_t            slot_d [DEPTH];
    entry_t            woke   [DEPTH];
    entry_t            up     [DEPTH];
    entry_t            disp_entry;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   wr_pos;

    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  w_rs_valid, w_rt_valid;
    logic [DATA_W-1:0] w_rs_data [DEPTH];
    logic [DATA_W-1:0] w_rt_data [DEPTH];
    logic [DATA_W-1:0] rs_fwd    [DEPTH];
    logic [DATA_W-1:0] rt_fwd    [DEPTH];

    logic              sel_found;
    logic [IdxW-1:0]   sel_idx;
    logic              do_issue;
    logic              do_disp;

    for (genvar g = 0; g < DEPTH; g++) begin : gen_entry
        issueque_entry u_entry (
            .valid_i    (slot_q[g].valid),
            .rs_valid_i (slot_q[g].rs_valid),
            .rs_tag_i   (slot_q[g].rs_tag),
            .rs_data_i  (slot_q[g].rs_data),
            .rt_valid_i (slot_q[g].rt_valid),
            .rt_tag_i   (slot_q[g].rt_tag),
            .rt_data_i  (slot_q[g].rt_data),
            .cdb_valid_i(cdb_valid),
            .cdb_tag_i  (cdb_tagout),
            .cdb_data_i (cdb_out),
            .rs_valid_o (w_rs_valid[g]),
            .rs_data_o  (w_rs_data[g]),
            .rt_valid_o (w_rt_valid[g]),
            .rt_data_o  (w_rt_data[g]),
            .ready_o    (rdy[g]),
            .rs_fwd_o   (rs_fwd[g]),
            .rt_fwd_o   (rt_fwd[g])
        );
    end

    assign issueque_full = (count_q == CntW'(DEPTH));

    // Oldest-ready select; scanning downward leaves the lowest index last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
        ready_int = sel_found;
        opcode    = sel_found ? slot_q[sel_idx].opcode : '0;
        rsdata    = sel_found ? rs_fwd[sel_idx]        : '0;
        rtdata    = sel_found ? rt_fwd[sel_idx]        : '0;
        rdtag     = sel_found ? slot_q[sel_idx].rd_tag : '0;
    end

    // New entry as written, with any CDB tag it is waiting on captured now.
    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.opcode   = dispatch_opcode;
        disp_entry.rs_tag   = dispatch_rstag;
        disp_entry.rt_tag   = dispatch_rttag;
        disp_entry.rd_tag   = dispatch_rdtag;
        disp_entry.rs_valid = dispatch_rsvalid;
        disp_entry.rs_data  = dispatch_rsdata;
        disp_entry.rt_valid = dispatch_rtvalid;
        disp_entry.rt_data  = dispatch_rtdata;
        if (src_hit(dispatch_rsvalid, dispatch_rstag, cdb_valid, cdb_tagout)) begin
            disp_entry.rs_valid = 1'b1;
            disp_entry.rs_data  = cdb_out;
        end
        if (src_hit(dispatch_rtvalid, dispatch_rttag, cdb_valid, cdb_tagout)) begin
            disp_entry.rt_valid = 1'b1;
            disp_entry.rt_data  = cdb_out;
        end
    end

    // Next state: wakeup, then compaction past the granted slot, then dispatch.
    always_comb begin
        do_issue = issue_int & sel_found;
        do_disp  = dispatch_en & ~issueque_full;
        wr_pos   = count_q - CntW'(do_issue);
        count_d  = count_q - CntW'(do_issue) + CntW'(do_disp);
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]          = slot_q[i];
            woke[i].rs_valid = w_rs_valid[i];
            woke[i].rs_data  = w_rs_data[i];
            woke[i].rt_valid = w_rt_valid[i];
            woke[i].rt_data  = w_rt_data[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            up[i] = woke[i + 1];
        end
        up[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = (do_issue && (IdxW'(i) >= sel_idx)) ? up[i] : woke[i];
            if (do_disp && (CntW'(i) == wr_pos)) begin
                slot_d[i] = disp_entry;
            end
        end
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = '0;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_issueque_int.sv
// Self-checking bench for issueque_int: a queue-based reference model is
// compared against the DUT every cycle, plus literal spot checks per scenario.
module tb_issueque_int;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        dispatch_en = 1'b0;
    logic [3:0]  dispatch_opcode = '0;
    logic [31:0] dispatch_rsdata = '0;
    logic        dispatch_rsvalid = 1'b0;
    logic [5:0]  dispatch_rstag = '0;
    logic [31:0] dispatch_rtdata = '0;
    logic        dispatch_rtvalid = 1'b0;
    logic [5:0]  dispatch_rttag = '0;
    logic [5:0]  dispatch_rdtag = '0;
    logic        issueque_full;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tagout = '0;
    logic [31:0] cdb_out = '0;
    logic        ready_int;
    logic        issue_int = 1'b0;
    logic [3:0]  opcode;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [5:0]  rdtag;

    always #5 clk = ~clk;

    issueque_int #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .dispatch_en     (dispatch_en),
        .dispatch_opcode (dispatch_opcode),
        .dispatch_rsdata (dispatch_rsdata),
        .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rstag  (dispatch_rstag),
        .dispatch_rtdata (dispatch_rtdata),
        .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rttag  (dispatch_rttag),
        .dispatch_rdtag  (dispatch_rdtag),
        .issueque_full   (issueque_full),
        .cdb_valid       (cdb_valid),
        .cdb_tagout      (cdb_tagout),
        .cdb_out         (cdb_out),
        .ready_int       (ready_int),
        .issue_int       (issue_int),
        .opcode          (opcode),
        .rsdata          (rsdata),
        .rtdata          (rtdata),
        .rdtag           (rdtag)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rsd;
        logic        rsv;
        logic [5:0]  rst;
        logic [31:0] rtd;
        logic        rtv;
        logic [5:0]  rtt;
        logic [5:0]  rd;
    } mentry_t;

    mentry_t mq[$];
    int      checks = 0;
    int      errors = 0;
    bit      chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cdb_match(input logic [5:0] t);
        return cdb_valid && (t == cdb_tagout);
    endfunction

    // Is a source usable for select this cycle?
    function automatic bit src_ready(input logic v, input logic [5:0] t);
`ifdef ISSUEQUE_CDB_BYPASS_EN
        return v || cdb_match(t);
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] src_value(input logic v, input logic [31:0] d);
`ifdef ISSUEQUE_CDB_BYPASS_EN
        return v ? d : cdb_out;
`else
        return d;
`endif
    endfunction

    // Oldest entry with both sources usable, or -1.
    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++) begin
            if (src_ready(mq[i].rsv, mq[i].rst) && src_ready(mq[i].rtv, mq[i].rtt)) return i;
        end
        return -1;
    endfunction

    // Reference model state update.
    int      m_sel;
    int      m_n;
    mentry_t m_new;
    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            mq.delete();
        end else begin
            m_sel = model_sel();
            m_n   = mq.size();
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].rsv && cdb_match(mq[i].rst)) begin
                    mq[i].rsv = 1'b1;
                    mq[i].rsd = cdb_out;
                end
                if (!mq[i].rtv && cdb_match(mq[i].rtt)) begin
                    mq[i].rtv = 1'b1;
                    mq[i].rtd = cdb_out;
                end
            end
            if (issue_int && m_sel >= 0) mq.delete(m_sel);
            if (dispatch_en && m_n < DEPTH) begin
                m_new.op  = dispatch_opcode;
                m_new.rsd = dispatch_rsdata;
                m_new.rsv = dispatch_rsvalid;
                m_new.rst = dispatch_rstag;
                m_new.rtd = dispatch_rtdata;
                m_new.rtv = dispatch_rtvalid;
                m_new.rtt = dispatch_rttag;
                m_new.rd  = dispatch_rdtag;
                if (!m_new.rsv && cdb_match(m_new.rst)) begin
                    m_new.rsv = 1'b1;
                    m_new.rsd = cdb_out;
                end
                if (!m_new.rtv && cdb_match(m_new.rtt)) begin
                    m_new.rtv = 1'b1;
                    m_new.rtd = cdb_out;
                end
                mq.push_back(m_new);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    int          c_sel;
    logic [31:0] e_op, e_rs, e_rt, e_rd;
    always @(negedge clk) begin
        if (chk_en) begin
            c_sel = model_sel();
            e_op = '0; e_rs = '0; e_rt = '0; e_rd = '0;
            if (c_sel >= 0) begin
                e_op = 32'(mq[c_sel].op);
                e_rs = src_value(mq[c_sel].rsv, mq[c_sel].rsd);
                e_rt = src_value(mq[c_sel].rtv, mq[c_sel].rtd);
                e_rd = 32'(mq[c_sel].rd);
            end
            check("m_ready_int", 32'(ready_int), 32'(c_sel >= 0));
            check("m_full", 32'(issueque_full), 32'(mq.size() == DEPTH));
            check("m_opcode", 32'(opcode), e_op);
            check("m_rsdata", rsdata, e_rs);
            check("m_rtdata", rtdata, e_rt);
            check("m_rdtag", 32'(rdtag), e_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_en = 1'b0;
        issue_int   = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rsd, input logic rsv,
                        input logic [5:0] rst, input logic [31:0] rtd, input logic rtv,
                        input logic [5:0] rtt, input logic [5:0] rd);
        dispatch_en      = 1'b1;
        dispatch_opcode  = op;
        dispatch_rsdata  = rsd;
        dispatch_rsvalid = rsv;
        dispatch_rstag   = rst;
        dispatch_rtdata  = rtd;
        dispatch_rtvalid = rtv;
        dispatch_rttag   = rtt;
        dispatch_rdtag   = rd;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        check("rst_full", 32'(issueque_full), 32'd0);
        check("rst_ready", 32'(ready_int), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);

        // Dispatch and grant
        disp(4'h1, 32'd5, 1'b1, 6'h00, 32'd7, 1'b1, 6'h00, 6'h11);
        issue_int = 1'b1;
        tick();
        dispatch_en = 1'b0;
        check("t1_ready", 32'(ready_int), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h1);
        check("t1_rsdata", rsdata, 32'd5);
        check("t1_rtdata", rtdata, 32'd7);
        check("t1_rdtag", 32'(rdtag), 32'h11);
        tick();
        issue_int = 1'b0;
        check("t1_empty", 32'(ready_int), 32'd0);

        // Wakeup and age order
        disp(4'h2, 32'd0, 1'b0, 6'h22, 32'd3, 1'b1, 6'h00, 6'h01);
        tick();
        disp(4'h3, 32'd10, 1'b1, 6'h00, 32'd20, 1'b1, 6'h00, 6'h02);
        tick();
        idle();
        check("t2_b_first", 32'(opcode), 32'h3);
        cdb_valid = 1'b1; cdb_tagout = 6'h22; cdb_out = 32'hABCD;
        tick();
        idle();
        check("t2_a_op", 32'(opcode), 32'h2);
        check("t2_a_rs", rsdata, 32'hABCD);
        check("t2_a_rt", rtdata, 32'd3);
        issue_int = 1'b1;
        tick();
        check("t2_b_after", 32'(opcode), 32'h3);
        tick();
        idle();
        check("t2_drained", 32'(ready_int), 32'd0);

        // Full queue
        for (int k = 1; k <= 5; k++) begin
            disp(4'(k), 32'(k), 1'b1, 6'h00, 32'(k + 100), 1'b1, 6'h00, 6'(k));
            tick();
            if (k == 4) check("t3_full", 32'(issueque_full), 32'd1);
        end
        idle();
        issue_int = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t3_order", 32'(opcode), 32'(k));
            tick();
        end
        idle();
        check("t3_empty", 32'(ready_int), 32'd0);
        check("t3_notfull", 32'(issueque_full), 32'd0);

        // Dispatch-time capture
        disp(4'h5, 32'd1, 1'b1, 6'h00, 32'd0, 1'b0, 6'h09, 6'h05);
        cdb_valid = 1'b1; cdb_tagout = 6'h09; cdb_out = 32'h33;
        tick();
        idle();
        check("t4_ready", 32'(ready_int), 32'd1);
        check("t4_rtdata", rtdata, 32'h33);
        issue_int = 1'b1;
        tick();
        idle();

        // Flush priority
        for (int k = 0; k < 3; k++) begin
            disp(4'(k + 8), 32'(k), 1'b1, 6'h00, 32'(k), 1'b1, 6'h00, 6'(k));
            tick();
        end
        flush = 1'b1;
        issue_int = 1'b1;
        tick();
        idle();
        check("t5_ready", 32'(ready_int), 32'd0);
        check("t5_full", 32'(issueque_full), 32'd0);
        tick();
        check("t5_still_empty", 32'(ready_int), 32'd0);

        // Asynchronous reset mid-cycle
        disp(4'h6, 32'd60, 1'b1, 6'h00, 32'd61, 1'b1, 6'h00, 6'h06);
        tick();
        disp(4'h7, 32'd70, 1'b1, 6'h00, 32'd71, 1'b1, 6'h00, 6'h07);
        tick();
        idle();
        check("t6_pre", 32'(ready_int), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_ready", 32'(ready_int), 32'd0);
        check("t6_opcode", 32'(opcode), 32'd0);
        check("t6_rsdata", rsdata, 32'd0);
        check("t6_rdtag", 32'(rdtag), 32'd0);
        check("t6_full", 32'(issueque_full), 32'd0);
        tick();
        reset = 1'b1;
        disp(4'h9, 32'd90, 1'b1, 6'h00, 32'd91, 1'b1, 6'h00, 6'h09);
        tick();
        idle();
        check("t6_redispatch", 32'(opcode), 32'h9);
        issue_int = 1'b1;
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
